// File: rtl/peri_pkg.sv
// ---------------------------------------------------------------------------
// peri_pkg : register offsets, CTRL bit indices and drain FSM states
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package peri_pkg;

  localparam logic [1:0] PERI_OFS_TXDATA = 2'd0;
  localparam logic [1:0] PERI_OFS_GPO    = 2'd1;
  localparam logic [1:0] PERI_OFS_CTRL   = 2'd2;
  localparam logic [1:0] PERI_OFS_FLUSH  = 2'd3;

  localparam int CTRL_DRAIN_EN = 0;
  localparam int CTRL_OVF_CLR  = 1;
  localparam int CTRL_IRQ_EN   = 2;

  typedef enum logic [0:0] {
    DRAIN_EMPTY = 1'b0,
    DRAIN_FULL  = 1'b1
  } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/peri_sync_fifo.sv
// ---------------------------------------------------------------------------
// peri_sync_fifo : single-clock FIFO with flush; push accepted when full if popping
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module peri_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH[AW:0]);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/peri_write_sink.sv
// ---------------------------------------------------------------------------
// peri_write_sink : peripheral-write register window feeding a FIFO-backed stream
// Revision        : 1.0   (optional irq logic: define PERI_SINK_IRQ_EN)
// ---------------------------------------------------------------------------
`default_nettype none

module peri_write_sink
  import peri_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          DATA_W     = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          peri_web,
  input  logic [15:0]                   peri_addr,
  input  logic [DATA_W-1:0]             peri_datao,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             gpo,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          irq
);

  logic              hit;
  logic              wr_tx;
  logic              wr_gpo;
  logic              wr_ctrl;
  logic              wr_flush;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              ovf_event;
  logic              drain_en;
  drain_state_t      state;
  drain_state_t      state_nxt;

  assign hit      = ~peri_web && (peri_addr[15:2] == BASE_ADDR[15:2]);
  assign wr_tx    = hit && (peri_addr[1:0] == PERI_OFS_TXDATA);
  assign wr_gpo   = hit && (peri_addr[1:0] == PERI_OFS_GPO);
  assign wr_ctrl  = hit && (peri_addr[1:0] == PERI_OFS_CTRL);
  assign wr_flush = hit && (peri_addr[1:0] == PERI_OFS_FLUSH);

  // A full FIFO still accepts the push when the drain pops in the same cycle
  assign ovf_event = wr_tx && fifo_full && !fifo_pop;

  peri_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .pop   (fifo_pop),
    .flush (wr_flush),
    .wdata (peri_datao),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DRAIN_EMPTY;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (fifo_pop) out_data <= fifo_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      DRAIN_EMPTY: begin
        if (drain_en && !fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = DRAIN_FULL;
        end
      end
      DRAIN_FULL: begin
        if (out_ready) begin
          if (drain_en && !fifo_empty) fifo_pop = 1'b1;
          else                         state_nxt = DRAIN_EMPTY;
        end
      end
      default: state_nxt = DRAIN_EMPTY;
    endcase
  end

  assign out_valid = (state == DRAIN_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      gpo      <= '0;
      drain_en <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_gpo)  gpo      <= peri_datao;
      if (wr_ctrl) drain_en <= peri_datao[CTRL_DRAIN_EN];
      if (ovf_event)
        overflow <= 1'b1;
      else if (wr_ctrl && peri_datao[CTRL_OVF_CLR])
        overflow <= 1'b0;
    end
  end

`ifdef PERI_SINK_IRQ_EN
  logic irq_en;
  logic tx_done;
  logic tx_done_set;
  logic tx_done_clr;

  // Last word accepted with nothing left behind it
  assign tx_done_set = (state == DRAIN_FULL) && out_ready && fifo_empty;
  assign tx_done_clr = wr_tx || (wr_ctrl && peri_datao[CTRL_OVF_CLR]);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en  <= 1'b0;
      tx_done <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= peri_datao[CTRL_IRQ_EN];
      if (tx_done_clr)      tx_done <= 1'b0;
      else if (tx_done_set) tx_done <= 1'b1;
      irq <= irq_en && (overflow || tx_done);
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_peri_write_sink.sv
// ---------------------------------------------------------------------------
// tb_peri_write_sink : directed stimulus with a stream scoreboard for peri_write_sink
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_peri_write_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        peri_web = 1'b1;
  logic [15:0] peri_addr = '0;
  logic [15:0] peri_datao = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] gpo;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb [$];

`ifdef PERI_SINK_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  peri_write_sink dut (
    .clk        (clk),
    .rst        (rst),
    .peri_web   (peri_web),
    .peri_addr  (peri_addr),
    .peri_datao (peri_datao),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .gpo        (gpo),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge; the write is sampled on the next edge
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    peri_web   = 1'b0;
    peri_addr  = a;
    peri_datao = d;
    @(posedge clk);
    #1;
    peri_web = 1'b1;
  endtask

  task automatic push(input logic [15:0] d, input bit delivered);
    if (delivered) sb.push_back(d);
    wr(16'hFF00, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stream monitor: every handshake must match the next expected word
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: got %0h expected no word (t=%0t)", out_data, $time);
      end else begin
        logic [15:0] exp_w;
        exp_w = sb.pop_front();
        if (out_data !== exp_w) begin
          errors++;
          $display("FAIL stream_word: got %0h expected %0h (t=%0t)", out_data, exp_w, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_gpo", gpo, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_irq", irq, 0);

    // GPO write and out-of-window write
    wr(16'hFF01, 16'h1234);
    chk("gpo_write", gpo, 16'h1234);
    chk("gpo_count", fifo_count, 0);
    chk("gpo_valid", out_valid, 0);
    chk("gpo_ovf", overflow, 0);
    wr(16'hFF05, 16'h5555);
    chk("gpo_miss", gpo, 16'h1234);

    // Basic drain
    out_ready = 1'b1;
    wr(16'hFF02, 16'h0001);
    push(16'h000A, 1);
    chk("drain_cnt1", fifo_count, 1);
    chk("drain_lat0", out_valid, 0);
    push(16'h000B, 1);
    chk("drain_lat1", out_valid, 1);
    chk("drain_first", out_data, 16'h000A);
    push(16'h000C, 1);
    idle(3);
    chk("drain_cnt0", fifo_count, 0);
    chk("drain_idle", out_valid, 0);

    // Overflow
    wr(16'hFF02, 16'h0000);
    for (int i = 0; i < 9; i++) push(16'h0010 + 16'(i), i < 8);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_set", overflow, 1);
    wr(16'hFF02, 16'h0002);
    chk("ovf_clear", overflow, 0);
    chk("ovf_count_kept", fifo_count, 8);
    wr(16'hFF02, 16'h0001);
    idle(12);
    chk("ovf_drained", fifo_count, 0);
    chk("ovf_idle", out_valid, 0);

    // Backpressure
    out_ready = 1'b0;
    push(16'h0021, 1);
    push(16'h0022, 0);
    push(16'h0023, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 16'h0021);
      idle(1);
    end
    chk("bp_count", fifo_count, 2);
    wr(16'hFF02, 16'h0000);
    chk("bp_hold", out_valid, 1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("bp_done", out_valid, 0);
    chk("bp_left", fifo_count, 2);
    wr(16'hFF03, 16'h0000);
    chk("bp_flush", fifo_count, 0);

    // Flush with a word in the output register
    wr(16'hFF02, 16'h0001);
    push(16'h0031, 1);
    push(16'h0032, 0);
    push(16'h0033, 0);
    push(16'h0034, 0);
    chk("fl_count", fifo_count, 3);
    chk("fl_valid", out_valid, 1);
    chk("fl_data", out_data, 16'h0031);
    wr(16'hFF03, 16'hBEEF);
    chk("fl_empty", fifo_count, 0);
    chk("fl_keep", out_valid, 1);
    out_ready = 1'b1;
    idle(4);
    chk("fl_idle", out_valid, 0);
    chk("fl_count0", fifo_count, 0);

    // Interrupt on transmit completion
    wr(16'hFF02, 16'h0005);
    push(16'h0041, 1);
    push(16'h0042, 1);
    idle(1);
    chk("irq_busy", irq, 0);
    idle(1);
    chk("irq_last_hs", irq, 0);
    idle(1);
    chk("irq_set", irq, IRQ_ON);
    push(16'h0050, 1);
    chk("irq_hold", irq, IRQ_ON);
    idle(1);
    chk("irq_clear", irq, 0);

    idle(5);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
